ahb_interconnect_decoder_mux: RTL

// - N-slave AHB-Lite address decoder + response mux between one bus master and NUM_SLAVES slave regions.
// - Decodes each address phase against per-slave base/size windows and drives one-hot HSEL.
// - Registers the data-phase owner and steers HRDATA/HREADY/HRESP back from that slave.
// - An internal default slave answers unmapped accesses with a two-cycle ERROR.

---
 rtl/ahb_interconnect_decoder_mux_if.sv | 55 +++++
 rtl/ahb_interconnect_decoder_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_interconnect_decoder_mux_if.sv
// Bus bundle for ahb_interconnect_decoder_mux.
// S_* faces the single AHB-Lite master, M_* faces the NUM_SLAVES slave regions.
// Modport "slave" is the decoder/mux view; modport "master" is the surrounding fabric view.
interface ahb_interconnect_decoder_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // master side
  logic                  S_HSEL;
  logic [ADDR_WIDTH-1:0] S_HADDR;
  logic [1:0]            S_HTRANS;
  logic                  S_HWRITE;
  logic [2:0]            S_HSIZE;
  logic [2:0]            S_HBURST;
  logic [3:0]            S_HPROT;
  logic                  S_HMASTLOCK;
  logic [DATA_WIDTH-1:0] S_HWDATA;
  logic                  S_HREADY;
  logic                  S_HRESP;
  logic [DATA_WIDTH-1:0] S_HRDATA;
  // slave side
  logic [NUM_SLAVES-1:0] M_HSEL;
  logic [ADDR_WIDTH-1:0] M_HADDR;
  logic [1:0]            M_HTRANS;
  logic                  M_HWRITE;
  logic [2:0]            M_HSIZE;
  logic [2:0]            M_HBURST;
  logic [3:0]            M_HPROT;
  logic                  M_HMASTLOCK;
  logic [DATA_WIDTH-1:0] M_HWDATA;
  logic                  M_HREADY;
  logic [NUM_SLAVES-1:0] M_HREADYOUT;
  logic [NUM_SLAVES-1:0] M_HRESP;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] M_HRDATA;
  logic                  TIMEOUT_FLAG;

  modport slave (
    input  S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HWDATA,
    output S_HREADY, S_HRESP, S_HRDATA,
    output M_HSEL, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, M_HWDATA,
    output M_HREADY,
    input  M_HREADYOUT, M_HRESP, M_HRDATA,
    output TIMEOUT_FLAG
  );

  modport master (
    output S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HWDATA,
    input  S_HREADY, S_HRESP, S_HRDATA,
    input  M_HSEL, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, M_HWDATA,
    input  M_HREADY,
    output M_HREADYOUT, M_HRESP, M_HRDATA,
    input  TIMEOUT_FLAG
  );
endinterface

// File: rtl/ahb_interconnect_decoder_mux.sv
// AHB-Lite address decoder + response mux, one master to NUM_SLAVES regions.
// Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR from an internal default slave.
// Optional wait-state watchdog: define AHB_DECODE_TIMEOUT_EN.

// One region window compare: upper address bits above the window size must equal the base.
module ahb_region_match #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter int                    LOG2       = 20
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  match
);
  if (LOG2 >= ADDR_WIDTH) begin : g_all
    // window covers the whole address space
    assign match = 1'b1;
  end else begin : g_cmp
    assign match = (addr[ADDR_WIDTH-1:LOG2] == BASE[ADDR_WIDTH-1:LOG2]);
  end
endmodule

module ahb_interconnect_decoder_mux #(
  parameter int                               NUM_SLAVES     = 4,
  parameter int                               DATA_WIDTH     = 32,
  parameter int                               ADDR_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS     = '0,
  parameter logic [NUM_SLAVES*8-1:0]          REGION_LOG2    = {NUM_SLAVES{8'd20}},
  parameter int                               TIMEOUT_CYCLES = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  ahb_interconnect_decoder_mux_if.slave bus
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_slaves
    $error("ahb_interconnect_decoder_mux: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ahb_interconnect_decoder_mux: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [NUM_SLAVES-1:0] win, hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  hit_any;
  logic                  xfer, unmapped, err_start, timeout_fire;
  logic                  dsel_valid, dsel_dflt;
  logic [IDX_W-1:0]      dsel_idx;
  ds_state_t             ds_state;
  logic                  ds_hready, ds_hresp;
  logic                  s_hready, s_hresp;
  logic [DATA_WIDTH-1:0] s_hrdata;

  // ---------------- address decode ----------------
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_win
    ahb_region_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE       (BASE_ADDRS[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .LOG2       (int'(REGION_LOG2[k*8 +: 8]))
    ) u_match (
      .addr  (bus.S_HADDR),
      .match (win[k])
    );
  end

  assign hit = win & {NUM_SLAVES{bus.S_HSEL}};

  // Priority encode the hits, lowest slave index wins on overlap
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_idx = IDX_W'(k);
        hit_any = 1'b1;
      end
    end
  end

  // isolate lowest set bit -> one-hot select
  assign bus.M_HSEL = hit & (~hit + NUM_SLAVES'(1));

  assign xfer      = bus.S_HSEL & bus.S_HTRANS[1];
  assign unmapped  = xfer & ~hit_any;
  assign err_start = (s_hready & unmapped) | timeout_fire;

  // ---------------- broadcast pass-through ----------------
  assign bus.M_HADDR     = bus.S_HADDR;
  assign bus.M_HTRANS    = bus.S_HTRANS;
  assign bus.M_HWRITE    = bus.S_HWRITE;
  assign bus.M_HSIZE     = bus.S_HSIZE;
  assign bus.M_HBURST    = bus.S_HBURST;
  assign bus.M_HPROT     = bus.S_HPROT;
  assign bus.M_HMASTLOCK = bus.S_HMASTLOCK;
  assign bus.M_HWDATA    = bus.S_HWDATA;
  assign bus.M_HREADY    = s_hready;

  // Data-phase owner, captured whenever an address phase is accepted
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_valid <= 1'b0;
      dsel_dflt  <= 1'b0;
      dsel_idx   <= '0;
    end else if (s_hready) begin
      dsel_valid <= xfer;
      dsel_dflt  <= unmapped;
      dsel_idx   <= hit_idx;
    end else if (timeout_fire) begin
      // abandon the stuck slave; the default slave owns the rest of this data phase
      dsel_valid <= 1'b0;
      dsel_dflt  <= 1'b1;
    end
  end

  // Default slave: two-cycle ERROR for unmapped transfers and abandoned data phases
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state  <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= 1'b0;
    end else begin
      case (ds_state)
        DS_IDLE: begin
          if (err_start) begin
            ds_state  <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= 1'b1;
          end
        end
        DS_ERR1: begin
          ds_state  <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= 1'b1;
        end
        DS_ERR2: begin
          if (err_start) begin
            ds_state  <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= 1'b1;
          end else begin
            ds_state  <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= 1'b0;
          end
        end
        default: begin
          ds_state  <= DS_IDLE;
          ds_hready <= 1'b1;
          ds_hresp  <= 1'b0;
        end
      endcase
    end
  end

  // Response mux: default slave, else owning slave, else idle OKAY
  always_comb begin
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    s_hrdata = '0;
    if (HRESET) begin
      s_hready = 1'b1;
    end else if (ds_state != DS_IDLE) begin
      s_hready = ds_hready;
      s_hresp  = ds_hresp;
    end else if (dsel_valid && !dsel_dflt) begin
      s_hready = bus.M_HREADYOUT[dsel_idx];
      s_hresp  = bus.M_HRESP[dsel_idx];
      s_hrdata = bus.M_HRDATA[dsel_idx];
    end
  end

  assign bus.S_HREADY = s_hready;
  assign bus.S_HRESP  = s_hresp;
  assign bus.S_HRDATA = s_hrdata;

`ifdef AHB_DECODE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_flag;
  logic            stall;

  assign stall        = dsel_valid & ~dsel_dflt & (ds_state == DS_IDLE) & ~s_hready;
  assign timeout_fire = stall & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Wait-state watchdog; flag stays set until reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (s_hready || timeout_fire) to_cnt <= '0;
      else if (stall)               to_cnt <= to_cnt + TO_W'(1);
      if (timeout_fire)             to_flag <= 1'b1;
    end
  end

  assign bus.TIMEOUT_FLAG = to_flag;
`else
  assign timeout_fire     = 1'b0;
  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

endmodule
